dmem_arbiter_rr: RTL and testbench

Parametrised round-robin data-memory arbiter. It lets N_CORES cores share one single-port data memory. Each core's request is held until the arbiter returns a one-cycle `memAV` completion pulse. The arbiter adds fair rotation, per-core halt masking and a configurable memory read latency. It sits between the core array and `data_mem` in the multi-core processor top.

---
 rtl/dmem_arbiter_rr.sv | 158 +++++++++++++++
 tb/tb_dmem_arbiter_rr.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_arbiter_rr.sv
// Round-robin arbiter sharing one single-port data memory among N_CORES cores.
// Requests are level-held until the one-cycle memAV completion pulse; all outputs are registered.
module dmem_arbiter_rr #(
    parameter int WIDTH   = 8,
    parameter int N_CORES = 4,
    parameter int RD_LAT  = 1
) (
    input  logic                       Clk,
    input  logic                       rst_n,
    input  logic [N_CORES-1:0]         coreS,
    input  logic [N_CORES-1:0]         memREAD,
    input  logic [N_CORES-1:0]         memWE,
    input  logic [N_CORES*WIDTH-1:0]   AR,
    input  logic [N_CORES*WIDTH-1:0]   DR,
    output logic [N_CORES-1:0]         memAV,
    output logic [N_CORES*WIDTH-1:0]   MEM_out,
    output logic [WIDTH-1:0]           addr,
    output logic [WIDTH-1:0]           DR_OUT,
    output logic                       rEN,
    output logic                       wEN,
    input  logic [WIDTH-1:0]           MEM,
    output logic                       busy,
    output logic [$clog2(N_CORES)-1:0] grant_id
);
    localparam int GW = $clog2(N_CORES);
    localparam int CW = $clog2(RD_LAT + 1);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;

    state_t                     state_q, state_d;
    logic [GW-1:0]              ptr_q, ptr_d;
    logic [GW-1:0]              gnt_q, gnt_d;
    logic                       is_wr_q, is_wr_d;
    logic [WIDTH-1:0]           addr_q, addr_d;
    logic [WIDTH-1:0]           dout_q, dout_d;
    logic                       ren_q, ren_d;
    logic                       wen_q, wen_d;
    logic                       busy_q, busy_d;
    logic [N_CORES-1:0]         memav_q, memav_d;
    logic [N_CORES*WIDTH-1:0]   mem_out_q, mem_out_d;
    logic [CW-1:0]              cnt_q, cnt_d;

    logic [N_CORES-1:0]         req_vld;
    logic                       found;
    logic [GW-1:0]              win;
    logic [GW-1:0]              win_next;

    assign req_vld = (memREAD | memWE) & ~coreS;

    // Search starts at the pointer and wraps; first valid core wins.
    always_comb begin
        found = 1'b0;
        win   = '0;
        for (int k = 0; k < N_CORES; k++) begin
            int idx;
            idx = (int'(ptr_q) + k) % N_CORES;
            if (!found && req_vld[idx]) begin
                found = 1'b1;
                win   = GW'(idx);
            end
        end
        win_next = (win == GW'(N_CORES - 1)) ? '0 : win + GW'(1);
    end

    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr_q;
        gnt_d     = gnt_q;
        is_wr_d   = is_wr_q;
        addr_d    = addr_q;
        dout_d    = dout_q;
        ren_d     = 1'b0;
        wen_d     = 1'b0;
        busy_d    = busy_q;
        memav_d   = '0;
        mem_out_d = mem_out_q;
        cnt_d     = cnt_q;
        case (state_q)
            IDLE: begin
                if (found) begin
                    state_d = ISSUE;
                    ptr_d   = win_next;
                    gnt_d   = win;
                    // Write wins when both read and write are raised.
                    is_wr_d = memWE[win];
                    addr_d  = AR[int'(win)*WIDTH +: WIDTH];
                    dout_d  = DR[int'(win)*WIDTH +: WIDTH];
                    wen_d   = memWE[win];
                    ren_d   = ~memWE[win];
                    busy_d  = 1'b1;
                end
            end
            ISSUE: begin
                if (is_wr_q) begin
                    state_d        = DONE;
                    memav_d[gnt_q] = 1'b1;
                end else begin
                    state_d = WAIT;
                    cnt_d   = CW'(RD_LAT - 1);
                end
            end
            WAIT: begin
                if (cnt_q == '0) begin
                    state_d                               = DONE;
                    mem_out_d[int'(gnt_q)*WIDTH +: WIDTH] = MEM;
                    memav_d[gnt_q]                        = 1'b1;
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            DONE: begin
                state_d = IDLE;
                busy_d  = 1'b0;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge Clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            ptr_q     <= '0;
            gnt_q     <= '0;
            is_wr_q   <= 1'b0;
            addr_q    <= '0;
            dout_q    <= '0;
            ren_q     <= 1'b0;
            wen_q     <= 1'b0;
            busy_q    <= 1'b0;
            memav_q   <= '0;
            mem_out_q <= '0;
            cnt_q     <= '0;
        end else begin
            state_q   <= state_d;
            ptr_q     <= ptr_d;
            gnt_q     <= gnt_d;
            is_wr_q   <= is_wr_d;
            addr_q    <= addr_d;
            dout_q    <= dout_d;
            ren_q     <= ren_d;
            wen_q     <= wen_d;
            busy_q    <= busy_d;
            memav_q   <= memav_d;
            mem_out_q <= mem_out_d;
            cnt_q     <= cnt_d;
        end
    end

    assign memAV    = memav_q;
    assign MEM_out  = mem_out_q;
    assign addr     = addr_q;
    assign DR_OUT   = dout_q;
    assign rEN      = ren_q;
    assign wEN      = wen_q;
    assign busy     = busy_q;
    assign grant_id = gnt_q;

endmodule

// File: tb/tb_dmem_arbiter_rr.sv
// Directed bench for dmem_arbiter_rr: instance A uses RD_LAT=1, instance B uses RD_LAT=3,
// each with its own behavioural single-port memory.
module tb_dmem_arbiter_rr;
    logic Clk;
    int checks = 0;
    int errors = 0;

    logic        a_rst_n, b_rst_n;
    logic [3:0]  a_coreS, a_rd, a_we, b_coreS, b_rd, b_we;
    logic [31:0] a_AR, a_DR, b_AR, b_DR;
    logic [3:0]  a_memAV, b_memAV;
    logic [31:0] a_MEM_out, b_MEM_out;
    logic [7:0]  a_addr, a_dout, a_MEM, b_addr, b_dout, b_MEM;
    logic        a_rEN, a_wEN, a_busy, b_rEN, b_wEN, b_busy;
    logic [1:0]  a_gid, b_gid;

    logic [7:0]  a_mem [0:255];
    logic [7:0]  b_mem [0:255];
    logic [7:0]  a_pipe;
    logic [7:0]  b_pipe [0:2];

    dmem_arbiter_rr #(.WIDTH(8), .N_CORES(4), .RD_LAT(1)) u_a (
        .Clk(Clk), .rst_n(a_rst_n), .coreS(a_coreS), .memREAD(a_rd), .memWE(a_we),
        .AR(a_AR), .DR(a_DR), .memAV(a_memAV), .MEM_out(a_MEM_out), .addr(a_addr),
        .DR_OUT(a_dout), .rEN(a_rEN), .wEN(a_wEN), .MEM(a_MEM), .busy(a_busy),
        .grant_id(a_gid)
    );

    dmem_arbiter_rr #(.WIDTH(8), .N_CORES(4), .RD_LAT(3)) u_b (
        .Clk(Clk), .rst_n(b_rst_n), .coreS(b_coreS), .memREAD(b_rd), .memWE(b_we),
        .AR(b_AR), .DR(b_DR), .memAV(b_memAV), .MEM_out(b_MEM_out), .addr(b_addr),
        .DR_OUT(b_dout), .rEN(b_rEN), .wEN(b_wEN), .MEM(b_MEM), .busy(b_busy),
        .grant_id(b_gid)
    );

    initial begin
        Clk = 1'b0;
        forever #5 Clk = ~Clk;
    end

    // Memory models: data appears RD_LAT cycles after the address is presented.
    always @(posedge Clk) begin
        if (a_wEN) a_mem[a_addr] <= a_dout;
        a_pipe <= a_mem[a_addr];
    end
    assign a_MEM = a_pipe;

    always @(posedge Clk) begin
        if (b_wEN) b_mem[b_addr] <= b_dout;
        b_pipe[0] <= b_mem[b_addr];
        b_pipe[1] <= b_pipe[0];
        b_pipe[2] <= b_pipe[1];
    end
    assign b_MEM = b_pipe[2];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(negedge Clk);
    endtask

    initial begin
        int seq [4];
        seq = '{0, 2, 0, 2};
        a_rst_n = 1'b0; b_rst_n = 1'b0;
        a_coreS = '0; a_rd = '0; a_we = '0; a_AR = '0; a_DR = '0;
        b_coreS = '0; b_rd = '0; b_we = '0; b_AR = '0; b_DR = '0;
        repeat (2) cyc();

        chk("rst_memAV", a_memAV, 0);
        chk("rst_rEN", a_rEN, 0);
        chk("rst_wEN", a_wEN, 0);
        chk("rst_busy", a_busy, 0);
        chk("rst_gid", a_gid, 0);
        chk("rst_addr", a_addr, 0);
        chk("rst_dout", a_dout, 0);
        chk("rst_memout", a_MEM_out, 0);
        a_rst_n = 1'b1; b_rst_n = 1'b1;
        cyc();

        // Single write: core 2 writes 0x5A to 0x40
        a_we[2] = 1'b1; a_AR[16 +: 8] = 8'h40; a_DR[16 +: 8] = 8'h5A;
        cyc();
        chk("wr_wEN", a_wEN, 1);
        chk("wr_rEN", a_rEN, 0);
        chk("wr_addr", a_addr, 8'h40);
        chk("wr_dout", a_dout, 8'h5A);
        chk("wr_gid", a_gid, 2);
        chk("wr_busy", a_busy, 1);
        chk("wr_memAV_early", a_memAV, 0);
        cyc();
        chk("wr_memAV", a_memAV, 4'b0100);
        chk("wr_wEN_off", a_wEN, 0);
        chk("wr_busy_done", a_busy, 1);
        a_we[2] = 1'b0;
        cyc();
        chk("wr_memAV_off", a_memAV, 0);
        chk("wr_busy_off", a_busy, 0);
        chk("wr_mem", a_mem[8'h40], 8'h5A);

        // Read RD_LAT=1: core 1 reads 0x40
        a_rd[1] = 1'b1; a_AR[8 +: 8] = 8'h40;
        cyc();
        chk("rd1_rEN", a_rEN, 1);
        chk("rd1_wEN", a_wEN, 0);
        chk("rd1_gid", a_gid, 1);
        chk("rd1_addr", a_addr, 8'h40);
        cyc();
        chk("rd1_wait_memAV", a_memAV, 0);
        chk("rd1_wait_rEN", a_rEN, 0);
        cyc();
        chk("rd1_memAV", a_memAV, 4'b0010);
        chk("rd1_memout", a_MEM_out, 32'h0000_5A00);
        a_rd[1] = 1'b0;
        cyc();

        // Read/write conflict on core 0: treated as write
        a_rd[0] = 1'b1; a_we[0] = 1'b1; a_AR[0 +: 8] = 8'h41; a_DR[0 +: 8] = 8'h77;
        cyc();
        chk("cf_wEN", a_wEN, 1);
        chk("cf_rEN", a_rEN, 0);
        chk("cf_gid", a_gid, 0);
        cyc();
        chk("cf_memAV", a_memAV, 4'b0001);
        a_rd[0] = 1'b0; a_we[0] = 1'b0;
        cyc();
        chk("cf_memout", a_MEM_out, 32'h0000_5A00);
        chk("cf_mem", a_mem[8'h41], 8'h77);

        // Core 3 writes 0x33 to 0x10 (pointer wraps back to 0)
        a_we[3] = 1'b1; a_AR[24 +: 8] = 8'h10; a_DR[24 +: 8] = 8'h33;
        cyc();
        chk("w3_gid", a_gid, 3);
        cyc();
        chk("w3_memAV", a_memAV, 4'b1000);
        a_we[3] = 1'b0;
        cyc();

        // Fairness: all four read together
        a_AR[16 +: 8] = 8'h10; a_AR[24 +: 8] = 8'h40;
        a_rd = 4'hF;
        for (int k = 0; k < 4; k++) begin
            cyc();
            chk("fair_gid", a_gid, k);
            chk("fair_rEN", a_rEN, 1);
            cyc();
            cyc();
            chk("fair_memAV", a_memAV, 32'(1 << k));
            a_rd[k] = 1'b0;
            cyc();
            chk("fair_idle", a_busy, 0);
        end
        chk("fair_memout", a_MEM_out, 32'h5A33_5A77);

        // Cores 0 and 2 re-request continuously: grants alternate
        a_AR[0 +: 8] = 8'h20; a_DR[0 +: 8] = 8'hA0;
        a_AR[16 +: 8] = 8'h22; a_DR[16 +: 8] = 8'hA2;
        a_we[0] = 1'b1; a_we[2] = 1'b1;
        for (int j = 0; j < 4; j++) begin
            cyc();
            chk("alt_gid", a_gid, seq[j]);
            cyc();
            chk("alt_memAV", a_memAV, 32'(1 << seq[j]));
            a_we[seq[j]] = 1'b0;
            cyc();
            a_we[seq[j]] = 1'b1;
        end
        a_we = '0;
        cyc();
        chk("alt_mem0", a_mem[8'h20], 8'hA0);
        chk("alt_mem2", a_mem[8'h22], 8'hA2);

        // Halt masking: halted core 3 is never granted
        a_coreS[3] = 1'b1; a_we[3] = 1'b1; a_DR[24 +: 8] = 8'hC3;
        for (int k = 0; k < 5; k++) begin
            cyc();
            chk("halt_busy", a_busy, 0);
        end
        a_coreS[3] = 1'b0;
        cyc();
        chk("halt_gid", a_gid, 3);
        chk("halt_wEN", a_wEN, 1);
        a_coreS[3] = 1'b1;
        cyc();
        chk("halt_memAV", a_memAV, 4'b1000);
        a_we[3] = 1'b0; a_coreS[3] = 1'b0;
        cyc();

        // Instance B (RD_LAT=3): seed memory with a write from core 2
        b_we[2] = 1'b1; b_AR[16 +: 8] = 8'h40; b_DR[16 +: 8] = 8'h5A;
        cyc();
        chk("b_wr_wEN", b_wEN, 1);
        cyc();
        chk("b_wr_memAV", b_memAV, 4'b0100);
        b_we[2] = 1'b0;
        cyc();

        // Core 1 read with RD_LAT=3
        b_rd[1] = 1'b1; b_AR[8 +: 8] = 8'h40;
        cyc();
        chk("rd3_rEN", b_rEN, 1);
        chk("rd3_gid", b_gid, 1);
        for (int k = 0; k < 3; k++) begin
            cyc();
            chk("rd3_wait_memAV", b_memAV, 0);
        end
        cyc();
        chk("rd3_memAV", b_memAV, 4'b0010);
        chk("rd3_memout", b_MEM_out, 32'h0000_5A00);
        b_rd[1] = 1'b0;
        cyc();

        // Reset mid-WAIT on core 2 read
        b_rd[2] = 1'b1; b_AR[16 +: 8] = 8'h40;
        cyc();
        chk("rw_rEN", b_rEN, 1);
        chk("rw_gid", b_gid, 2);
        cyc();
        #2 b_rst_n = 1'b0;
        #1;
        chk("rw_memAV", b_memAV, 0);
        chk("rw_busy", b_busy, 0);
        chk("rw_gid0", b_gid, 0);
        chk("rw_addr", b_addr, 0);
        chk("rw_dout", b_dout, 0);
        chk("rw_memout", b_MEM_out, 0);
        b_rd = '0;
        cyc();
        b_rst_n = 1'b1;
        for (int k = 0; k < 4; k++) begin
            cyc();
            chk("rw_no_memAV", b_memAV, 0);
        end
        b_rd[0] = 1'b1; b_rd[3] = 1'b1;
        cyc();
        chk("rw_first_gid", b_gid, 0);
        chk("rw_first_busy", b_busy, 1);
        b_rd = '0;
        repeat (6) cyc();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
